// File: rtl/csi_packet_scheduler.sv
// csi_packet_scheduler
// Frames one CSI-2 frame into a byte-wide TX FIFO:
// FS short packet, IMAGE_LINES long packets (header, payload, checksum footer), FE short packet.
//
// Handshakes (valid/ready):
// - Payload input: a byte moves on a rising edge where pix_valid & pix_ready are both high.
//   pix_ready never depends on pix_valid.
// - FIFO output: a byte is written on a rising edge where fifo_wr is high.
//   fifo_wr is never high while fifo_full is high.
// The FSM state is exported on state_dbg so checkers can bind to it.
module csi_packet_scheduler #(
  parameter logic [1:0] VIRTUAL_CHANNEL   = 2'h0,
  parameter int         IMAGE_LINES       = 4,
  parameter int         IMAGE_LINE_PIXELS = 16,
  parameter int         IMAGE_PIXEL_WIDTH = 14,
  parameter int         IMAGE_LINE_GAP    = 8,
  parameter logic [7:0] ECC               = 8'hCC,
  parameter logic [5:0] PIXEL_DATA_TYPE   = 6'h2D,
  parameter logic [5:0] FS_DATA_TYPE      = 6'h0,
  parameter logic [5:0] FE_DATA_TYPE      = 6'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        fifo_full,
  output logic [7:0]  fifo_wdata,
  output logic        fifo_wr,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_num,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FS   = 3'd1,
    S_GAP  = 3'd2,
    S_LHDR = 3'd3,
    S_LPAY = 3'd4,
    S_LFTR = 3'd5,
    S_FE   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam int          WC_INT     = IMAGE_LINE_PIXELS * IMAGE_PIXEL_WIDTH / 8;
  localparam logic [15:0] WC         = 16'(WC_INT);
  localparam logic [15:0] WC_LAST    = 16'(WC_INT - 1);
  localparam logic [15:0] GAP_LAST   = 16'((IMAGE_LINE_GAP > 0) ? (IMAGE_LINE_GAP - 1) : 0);
  localparam logic [15:0] LINES_LAST = 16'(IMAGE_LINES - 1);
  // With no inter-line gap a line header follows immediately.
  localparam state_t      LINE_ENTRY = (IMAGE_LINE_GAP == 0) ? S_LHDR : S_GAP;

  state_t      state, state_nx;
  logic [15:0] cnt;       // byte index in header/payload/footer, cycle index in GAP
  logic [15:0] line;      // current line number within the frame
  logic [15:0] csum;      // running payload checksum of the current line

  // Short packet bytes: {VC,DT}, frame_num low, frame_num high, ECC.
  function automatic logic [7:0] short_byte(input logic [5:0] dt, input logic [1:0] idx,
                                            input logic [15:0] fn);
    case (idx)
      2'd0:    short_byte = {VIRTUAL_CHANNEL, dt};
      2'd1:    short_byte = fn[7:0];
      2'd2:    short_byte = fn[15:8];
      default: short_byte = ECC;
    endcase
  endfunction

  // Long packet header bytes: {VC,DT}, WC low, WC high, ECC.
  function automatic logic [7:0] line_hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    line_hdr_byte = {VIRTUAL_CHANNEL, PIXEL_DATA_TYPE};
      2'd1:    line_hdr_byte = WC[7:0];
      2'd2:    line_hdr_byte = WC[15:8];
      default: line_hdr_byte = ECC;
    endcase
  endfunction

  assign state_dbg  = state;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign frame_done = (state == S_DONE);

  // Next-state and byte-emission logic; outputs idle at zero outside emitting states.
  always_comb begin
    state_nx   = state;
    fifo_wr    = 1'b0;
    fifo_wdata = 8'h00;
    pix_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) state_nx = S_FS;
      end
      S_FS: begin
        fifo_wr    = !fifo_full;
        fifo_wdata = short_byte(FS_DATA_TYPE, cnt[1:0], frame_num);
        if (fifo_wr && cnt == 16'd3) state_nx = LINE_ENTRY;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nx = S_LHDR;
      end
      S_LHDR: begin
        fifo_wr    = !fifo_full;
        fifo_wdata = line_hdr_byte(cnt[1:0]);
        if (fifo_wr && cnt == 16'd3) state_nx = S_LPAY;
      end
      S_LPAY: begin
        pix_ready  = !fifo_full;
        fifo_wr    = pix_valid && !fifo_full;
        fifo_wdata = pix_data;
        if (fifo_wr && cnt == WC_LAST) state_nx = S_LFTR;
      end
      S_LFTR: begin
        fifo_wr    = !fifo_full;
        fifo_wdata = cnt[0] ? csum[15:8] : csum[7:0];
        if (fifo_wr && cnt == 16'd1) state_nx = (line == LINES_LAST) ? S_FE : LINE_ENTRY;
      end
      S_FE: begin
        fifo_wr    = !fifo_full;
        fifo_wdata = short_byte(FE_DATA_TYPE, cnt[1:0], frame_num);
        if (fifo_wr && cnt == 16'd3) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register plus byte/cycle index, line counter, checksum and frame number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      line      <= 16'd0;
      csum      <= 16'd0;
      frame_num <= 16'd0;
    end else begin
      state <= state_nx;

      // The index restarts on every state change and otherwise moves per written byte
      // (or per cycle while waiting in the gap).
      if (state_nx != state)
        cnt <= 16'd0;
      else if (fifo_wr || state == S_GAP)
        cnt <= cnt + 16'd1;

      if (state == S_FS)
        line <= 16'd0;
      else if (state == S_LFTR && fifo_wr && cnt == 16'd1)
        line <= line + 16'd1;

      if (state == S_LHDR)
        csum <= 16'd0;
      else if (state == S_LPAY && fifo_wr)
        csum <= csum + {8'h00, pix_data};

      // Frame numbers skip 0 on wrap so 0 always means "no frame since reset".
      if (state == S_IDLE && frame_start)
        frame_num <= (frame_num == 16'hFFFF) ? 16'h0001 : frame_num + 16'd1;
    end
  end

endmodule
